// File: rtl/effect_noise_gate.sv
// effect_noise_gate
//
// Sample-rate noise gate placed ahead of the distortion stage. When the input
// envelope stays below a selectable threshold the gate fades the signal to
// silence so idle hiss is not amplified downstream. Opening and closing use
// linear gain ramps, a hold window and open/close hysteresis to avoid chatter.
//
// Parameters:
//   HOLD_SAMPLES  valid samples the gate stays fully open after the input
//                 drops below the close threshold
//   RAMP_SAMPLES  valid samples per gain step during attack/release (>= 1)
//
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset
//   i_valid   one-cycle strobe, i_data carries a new sample
//   i_enable  1 = gate active, 0 = bypass
//   i_level   threshold select (0 -> 128, 1..7 -> level*256)
//   i_data    signed 16-bit input sample
//   o_data    signed 16-bit gated sample, updated every clock
//   o_valid   strobe aligned to o_data, two clocks after i_valid
module effect_noise_gate #(
  parameter int HOLD_SAMPLES = 2048,
  parameter int RAMP_SAMPLES = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid
);

  localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
  localparam int RW = (RAMP_SAMPLES > 1) ? $clog2(RAMP_SAMPLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_SAMPLES - 1);
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_SAMPLES - 1);
  localparam logic [4:0]    G_UNITY   = 5'd16;

  typedef enum logic [2:0] {
    ST_CLOSED,
    ST_ATTACK,
    ST_OPEN,
    ST_HOLD,
    ST_RELEASE
  } state_t;

  state_t             state, state_nxt;
  logic [4:0]         g, g_nxt;
  logic [HW-1:0]      hold_cnt, hold_nxt;
  logic [RW-1:0]      ramp_cnt, ramp_nxt;

  logic signed [15:0] in_sat;
  logic [14:0]        in_abs;
  logic signed [15:0] p1_data;
  logic               p1_valid;
  logic               p1_enable;
  logic [2:0]         p1_level;
  logic [14:0]        p1_abs;

  logic [14:0]        thr_open, thr_close;
  logic [HW:0]        hold_inc;
  logic [RW-1:0]      ramp_in;
  logic               ramp_up, ramp_down, ramp_tick;
  logic signed [20:0] prod;

  // Clamp the one asymmetric code so |x| always fits in 15 bits and the
  // negated sample can never overflow.
  always_comb begin
    in_sat = (i_data == 16'sh8000) ? 16'sh8001 : i_data;
    in_abs = 15'(in_sat[15] ? -in_sat : in_sat);
  end

  // Stage 1: capture the sample, its magnitude and the controls that travel
  // with it, so a level change only affects the sample it arrived with.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p1_data   <= '0;
      p1_valid  <= 1'b0;
      p1_enable <= 1'b0;
      p1_level  <= '0;
      p1_abs    <= '0;
    end else begin
      p1_data   <= in_sat;
      p1_valid  <= i_valid;
      p1_enable <= i_enable;
      p1_level  <= i_level;
      p1_abs    <= in_abs;
    end
  end

  // Open threshold from the level select; the close threshold sits an octave
  // lower to give the hysteresis band.
  always_comb begin
    thr_open  = (p1_level == 3'd0) ? 15'd128 : {4'd0, p1_level, 8'd0};
    thr_close = thr_open >> 1;
  end

  // Gate state, gain and counters only move on enabled valid samples; bypass
  // forces everything back to silence so re-enabling always fades in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_CLOSED;
      g        <= '0;
      hold_cnt <= '0;
      ramp_cnt <= '0;
    end else begin
      state    <= state_nxt;
      g        <= g_nxt;
      hold_cnt <= hold_nxt;
      ramp_cnt <= ramp_nxt;
    end
  end

  // Next-state logic. The sample that starts a ramp counts as the first
  // sample of its first gain step, which is why ramp_in is zero (not the
  // stale counter) on entry and the step logic runs on that same sample.
  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    hold_nxt  = hold_cnt;
    ramp_nxt  = ramp_cnt;
    ramp_in   = ramp_cnt;
    ramp_up   = 1'b0;
    ramp_down = 1'b0;
    ramp_tick = 1'b0;
    hold_inc  = {1'b0, hold_cnt} + 1'b1;

    if (!p1_enable) begin
      state_nxt = ST_CLOSED;
      g_nxt     = '0;
      hold_nxt  = '0;
      ramp_nxt  = '0;
    end else if (p1_valid) begin
      unique case (state)
        ST_CLOSED: begin
          if (p1_abs >= thr_open) begin
            state_nxt = ST_ATTACK;
            ramp_in   = '0;
            ramp_up   = 1'b1;
          end
        end
        ST_ATTACK: begin
          ramp_up = 1'b1;
        end
        ST_OPEN: begin
          if (p1_abs < thr_close) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
          end
        end
        ST_HOLD: begin
          if (p1_abs >= thr_close) begin
            state_nxt = ST_OPEN;
          end else if (hold_inc >= {1'b0, HOLD_LAST}) begin
            state_nxt = ST_RELEASE;
            ramp_in   = '0;
            ramp_down = 1'b1;
          end else begin
            hold_nxt = hold_inc[HW-1:0];
          end
        end
        ST_RELEASE: begin
          if (p1_abs >= thr_open) begin
            state_nxt = ST_ATTACK;
            ramp_in   = '0;
            ramp_up   = 1'b1;
          end else begin
            ramp_down = 1'b1;
          end
        end
        default: begin
          state_nxt = ST_CLOSED;
          g_nxt     = '0;
        end
      endcase

      if (ramp_up || ramp_down) begin
        ramp_tick = (ramp_in == RAMP_LAST);
        ramp_nxt  = ramp_tick ? '0 : ramp_in + 1'b1;
        if (ramp_tick && ramp_up) begin
          g_nxt = g + 5'd1;
          if (g_nxt == G_UNITY) begin
            state_nxt = ST_OPEN;
          end
        end else if (ramp_tick && ramp_down) begin
          g_nxt = g - 5'd1;
          if (g_nxt == 5'd0) begin
            state_nxt = ST_CLOSED;
          end
        end
      end
    end
  end

  // Gain is applied as g/16 using the gain held before this sample's update;
  // the arithmetic shift floors toward -inf and g=16 is exact passthrough.
  always_comb begin
    prod = 21'(p1_data) * $signed({16'd0, g});
  end

  // Stage 2: output register, refreshed every clock like the downstream stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= p1_valid;
      o_data  <= p1_enable ? 16'(prod >>> 4) : p1_data;
    end
  end

endmodule

// File: tb/tb_effect_noise_gate.sv
// tb_effect_noise_gate
//
// Drives two gate instances with identical directed stimulus: instance A uses
// a two-sample ramp, instance B a one-sample ramp, both with a four-sample
// hold. A sample-level model of the gate rules predicts every output, and a
// compare process checks o_valid/o_data against it on every clock.
module tb_effect_noise_gate;

  localparam int HOLD_N = 4;
  localparam int RAMP_A = 2;
  localparam int RAMP_B = 1;

  localparam int P_CLOSED  = 0;
  localparam int P_ATTACK  = 1;
  localparam int P_OPEN    = 2;
  localparam int P_HOLD    = 3;
  localparam int P_RELEASE = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               valid;
  logic               enable;
  logic [2:0]         level;
  logic signed [15:0] data;
  logic signed [15:0] o_data_a, o_data_b;
  logic               o_valid_a, o_valid_b;

  always #5 clk = ~clk;

  effect_noise_gate #(.HOLD_SAMPLES(HOLD_N), .RAMP_SAMPLES(RAMP_A)) dut_a (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid),
    .i_enable (enable),
    .i_level  (level),
    .i_data   (data),
    .o_data   (o_data_a),
    .o_valid  (o_valid_a)
  );

  effect_noise_gate #(.HOLD_SAMPLES(HOLD_N), .RAMP_SAMPLES(RAMP_B)) dut_b (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (valid),
    .i_enable (enable),
    .i_level  (level),
    .i_data   (data),
    .o_data   (o_data_b),
    .o_valid  (o_valid_b)
  );

  typedef struct {
    int          due;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   chk_en   = 1'b0;

  int   m_phase[2];
  int   m_g[2];
  int   m_steps[2];
  int   m_quiet[2];
  int   ramp_len[2] = '{RAMP_A, RAMP_B};

  // Free-running cycle count used to time-stamp expected outputs.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%04h expected=0x%04h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = P_CLOSED;
      m_g[k]     = 0;
      m_steps[k] = 0;
      m_quiet[k] = 0;
    end
  endtask

  // One sample of a ramp: every ramp_len samples the gain moves one step.
  task automatic modelRamp(input int k, input int dir);
    m_steps[k]++;
    if (m_steps[k] == ramp_len[k]) begin
      m_steps[k] = 0;
      m_g[k]     = m_g[k] + dir;
      if (m_g[k] == 16) m_phase[k] = P_OPEN;
      else if (m_g[k] == 0) m_phase[k] = P_CLOSED;
    end
  endtask

  // Output for one enabled sample with the current gain, then apply the rules.
  task automatic modelSample(input int k, input int d, input int lvl, output int expv);
    int mag, open_thr, close_thr;
    expv      = (d * m_g[k]) >>> 4;
    mag       = (d < 0) ? -d : d;
    open_thr  = (lvl == 0) ? 128 : lvl * 256;
    close_thr = open_thr / 2;
    case (m_phase[k])
      P_CLOSED: begin
        if (mag >= open_thr) begin
          m_phase[k] = P_ATTACK;
          m_steps[k] = 0;
          modelRamp(k, 1);
        end
      end
      P_ATTACK: modelRamp(k, 1);
      P_OPEN: begin
        if (mag < close_thr) begin
          m_phase[k] = P_HOLD;
          m_quiet[k] = 0;
        end
      end
      P_HOLD: begin
        if (mag >= close_thr) begin
          m_phase[k] = P_OPEN;
        end else begin
          m_quiet[k]++;
          if (m_quiet[k] >= HOLD_N - 1) begin
            m_phase[k] = P_RELEASE;
            m_steps[k] = 0;
            modelRamp(k, -1);
          end
        end
      end
      default: begin
        if (mag >= open_thr) begin
          m_phase[k] = P_ATTACK;
          m_steps[k] = 0;
          modelRamp(k, 1);
        end else begin
          modelRamp(k, -1);
        end
      end
    endcase
  endtask

  // Drive one clock of input, predict both outputs and queue them two clocks out.
  task automatic applyStimulus(input bit v, input bit en, input logic [2:0] lvl,
                               input logic [15:0] d,
                               output logic [15:0] ea, output logic [15:0] eb);
    int   ds, xa, xb;
    exp_t e;
    valid  = v;
    enable = en;
    level  = lvl;
    data   = d;
    ds = (d == 16'h8000) ? -32767 : int'($signed(d));
    ea = 16'(ds);
    eb = 16'(ds);
    if (!en) begin
      modelReset();
    end else if (v) begin
      modelSample(0, ds, int'(lvl), xa);
      modelSample(1, ds, int'(lvl), xb);
      ea = 16'(xa);
      eb = 16'(xb);
    end
    if (v) begin
      e.due   = cyc + 2;
      e.exp_a = ea;
      e.exp_b = eb;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Compare process: an expected strobe must appear exactly on its cycle with
  // the predicted data, and no strobe may appear on any other cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        checkOutput("valid_a", {15'd0, o_valid_a}, 16'd1);
        checkOutput("valid_b", {15'd0, o_valid_b}, 16'd1);
        checkOutput("data_a", o_data_a, exp_q[0].exp_a);
        checkOutput("data_b", o_data_b, exp_q[0].exp_b);
        void'(exp_q.pop_front());
      end else begin
        checkOutput("idle_valid_a", {15'd0, o_valid_a}, 16'd0);
        checkOutput("idle_valid_b", {15'd0, o_valid_b}, 16'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the bench completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] ea, eb;
    rst_n  = 1'b0;
    valid  = 1'b0;
    enable = 1'b0;
    level  = 3'd0;
    data   = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_data_a", o_data_a, 16'h0000);
    checkOutput("reset_data_b", o_data_b, 16'h0000);
    checkOutput("reset_valid_a", {15'd0, o_valid_a}, 16'd0);
    checkOutput("reset_valid_b", {15'd0, o_valid_b}, 16'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 3'd4, 16'h0000, ea, eb);

    $display("[TB] bypass");
    applyStimulus(1'b1, 1'b0, 3'd4, 16'h1234, ea, eb);
    checkOutput("pin_bypass_1234", ea, 16'h1234);
    applyStimulus(1'b1, 1'b0, 3'd4, 16'h8000, ea, eb);
    checkOutput("pin_bypass_8000", ea, 16'h8001);
    applyStimulus(1'b1, 1'b0, 3'd4, 16'hFFFF, ea, eb);
    checkOutput("pin_bypass_ffff", ea, 16'hFFFF);
    applyStimulus(1'b0, 1'b0, 3'd4, 16'h0000, ea, eb);

    $display("[TB] attack");
    for (int i = 0; i < 40; i++) begin
      if (i % 5 == 4) applyStimulus(1'b0, 1'b1, 3'd4, 16'h0000, ea, eb);
      applyStimulus(1'b1, 1'b1, 3'd4, 16'h1000, ea, eb);
      if (i == 0) checkOutput("pin_attack_0", ea, 16'h0000);
      if (i == 1) checkOutput("pin_attack_b1", eb, 16'h0100);
      if (i == 2) checkOutput("pin_attack_2", ea, 16'h0100);
      if (i == 3) checkOutput("pin_attack_3", ea, 16'h0100);
      if (i == 4) checkOutput("pin_attack_4", ea, 16'h0200);
      if (i == 32) checkOutput("pin_attack_32", ea, 16'h1000);
    end

    $display("[TB] hold and release");
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd4, 16'h0100, ea, eb);
      if (i == 3) checkOutput("pin_hold_b3", eb, 16'h0100);
      if (i == 4) checkOutput("pin_release_b4", eb, 16'h00F0);
      if (i == 5) checkOutput("pin_release_b5", eb, 16'h00E0);
      if (i == 5) checkOutput("pin_release_a5", ea, 16'h00F0);
      if (i == 19) checkOutput("pin_release_b19", eb, 16'h0000);
    end

    $display("[TB] reopen and hysteresis");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd4, 16'h1000, ea, eb);
      if (i == 39) checkOutput("pin_reopen_a", ea, 16'h1000);
    end
    for (int i = 0; i < 16; i++) begin
      logic [15:0] hv;
      hv = (i % 2 == 0) ? 16'h0100 : 16'h0300;
      applyStimulus(1'b1, 1'b1, 3'd4, hv, ea, eb);
      checkOutput("pin_hyst_a", ea, hv);
      checkOutput("pin_hyst_b", eb, hv);
    end

    $display("[TB] re-trigger");
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b1, 3'd4, 16'h0100, ea, eb);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 3'd4, 16'h0400, ea, eb);
      if (i == 0) checkOutput("pin_retrig_b0", eb, 16'h0280);
      if (i == 1) checkOutput("pin_retrig_b1", eb, 16'h02C0);
      if (i == 0) checkOutput("pin_retrig_a0", ea, 16'h0340);
    end

    $display("[TB] negative samples during attack");
    applyStimulus(1'b1, 1'b0, 3'd4, 16'h0555, ea, eb);
    checkOutput("pin_bypass_0555", ea, 16'h0555);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 3'd4, 16'h1000, ea, eb);
    applyStimulus(1'b1, 1'b1, 3'd4, 16'hFC00, ea, eb);
    checkOutput("pin_neg_b", eb, 16'hFE00);
    checkOutput("pin_neg_a", ea, 16'hFF00);
    applyStimulus(1'b1, 1'b1, 3'd4, 16'h8000, ea, eb);
    checkOutput("pin_min_b", eb, 16'hB800);
    checkOutput("pin_min_a", ea, 16'hE000);

    $display("[TB] level 0 threshold");
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, ea, eb);
    applyStimulus(1'b1, 1'b1, 3'd0, 16'h007F, ea, eb);
    applyStimulus(1'b1, 1'b1, 3'd0, 16'h0080, ea, eb);
    applyStimulus(1'b1, 1'b1, 3'd0, 16'h0080, ea, eb);
    checkOutput("pin_level0_b", eb, 16'h0008);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 3'(i), 16'h0700, ea, eb);

    $display("[TB] mid-stream reset");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 3'd4, 16'h1000, ea, eb);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkOutput("midreset_data_a", o_data_a, 16'h0000);
    checkOutput("midreset_data_b", o_data_b, 16'h0000);
    checkOutput("midreset_valid_a", {15'd0, o_valid_a}, 16'd0);
    checkOutput("midreset_valid_b", {15'd0, o_valid_b}, 16'd0);
    exp_q.delete();
    modelReset();
    valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 3'd4, 16'h7FFF, ea, eb);
    checkOutput("pin_after_reset_a", ea, 16'h0000);
    checkOutput("pin_after_reset_b", eb, 16'h0000);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 3'd4, 16'h0000, ea, eb);
    checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/effect_noise_gate.md
# effect_noise_gate

Sample-rate noise gate that sits directly upstream of the distortion stage in the effects chain. It attenuates 16-bit signed audio to silence when the input envelope stays below a selectable threshold, so the distortion stage does not amplify idle hiss. Opening and closing use linear gain ramps, a hold window and hysteresis to avoid chatter. The output uses the same valid/data convention the distortion stage consumes.

## Interface
- HOLD_SAMPLES, 2048: valid samples the gate stays fully open after the input falls below the close threshold.
- RAMP_SAMPLES, 64: valid samples per gain step during attack and release (must be ≥1).
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_valid  input  1  one-cycle strobe; i_data is a new sample.
- i_enable  input  1  1 = gate active, 0 = bypass.
- i_level  input  3  threshold select.
- i_data  input  16  signed sample.
- o_data  output  16  signed gated sample.
- o_valid  output  1  strobe aligned to o_data.

## Operation
- Stage 1 (every clock): register data (0x8000 mapped to 0x8001), valid, enable, and |data| (15 bits, 0..0x7FFF).
- Thresholds: thr_open = {level,8'b0}, level 1..7 gives 256..1792; level 0 gives thr_open = 128. thr_close = thr_open >> 1.
- Gain register g: 5-bit unsigned, 0..16; 16 = unity.
- State and counters advance only when the stage-1 valid is high and the stage-1 enable is high.
- CLOSED: g=0. If abs ≥ thr_open, go to ATTACK and clear the ramp counter.
- ATTACK: the ramp counter counts valid samples. At RAMP_SAMPLES-1, g+=1 and the counter clears. When g reaches 16, go to OPEN. Input level is ignored in this state.
- OPEN: g=16. If abs < thr_close, go to HOLD and clear the hold counter.
- HOLD: g=16. If abs ≥ thr_close, return to OPEN. Otherwise the hold counter increments. At HOLD_SAMPLES-1, go to RELEASE and clear the ramp counter.
- RELEASE: if abs ≥ thr_open, go to ATTACK; g is kept and the ramp counter is cleared. Otherwise ramp down: g-=1 per RAMP_SAMPLES. When g reaches 0, go to CLOSED.
- Bypass: while the stage-1 enable is low, state is forced to CLOSED, g=0 and counters are cleared. Re-enabling therefore always fades in through ATTACK.
- Stage 2 arithmetic: product = p1_data × g, 21-bit signed. o_data = product >>> 4, truncated toward −inf. This always fits in 16 bits, and g=16 gives exact passthrough.
- When the stage-1 enable is low, o_data = p1_data unchanged.
- o_data updates every clock regardless of valid, as in the downstream stage. Consumers sample it only on o_valid.

## Timing
- Latency is 2 clocks: i_valid at edge N produces o_valid at edge N+2, with no bubbles. Every input strobe yields exactly one output strobe.
- The gain applied to a sample is the g value held before that sample's state update. The effect of a transition appears on the next valid sample.
- Reset values: o_data=0, o_valid=0, state=CLOSED, g=0, all counters and pipeline registers 0.
- Reset mid-ramp or mid-hold aborts immediately with no residual gain.
- i_level may change at any time. It is sampled in stage 1 with its sample, and no state reset occurs.
- Non-valid cycles freeze state, g and counters.
- Back-to-back valids (one per clock) are supported.
- Counter widths are $clog2 of the parameter, minimum 1 bit.

## Test plan
- Reset: assert i_rst_n low mid-stream -> o_data=0 and o_valid=0 immediately. After release, a 0x7FFF sample with enable=1 outputs 0, because the gate starts CLOSED.
- Bypass: enable=0, feed 0x1234, 0x8000, 0xFFFF -> outputs 0x1234, 0x8001, 0xFFFF, each 2 clocks later with matching o_valid.
- Attack: RAMP_SAMPLES=2, level=4 (thr_open=0x400), constant 0x1000 -> output sequence 0, 0, 0x0100, 0x0100, 0x0200, … reaching 0x1000 after 32 samples, then held.
- Hold/release: HOLD_SAMPLES=4, RAMP_SAMPLES=1. From OPEN, feed 0x0100 (below thr_close 0x200) -> four outputs of 0x0100, then 0x00F0, 0x00E0, … down to 0 and remaining 0.
- Hysteresis: from OPEN, alternate 0x0300 and 0x0100 around thr_close 0x200 with HOLD_SAMPLES=4 -> never leaves OPEN/HOLD, and output equals input.
- Re-trigger: during RELEASE at g=10, feed 0x0400 -> state goes to ATTACK and g climbs from 10 without a reset to 0. A negative sample −0x0400 at g=8 yields −0x0200.
